// File: rtl/rf_fifo_ctrl.sv
// rf_fifo_ctrl: FIFO controller over an external 2-port register file with
// 1-cycle read latency, plus a 2-entry output queue that keeps pops at full rate.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (has priority over i_flush)
//   i_flush      synchronous clear of all stored entries
//   i_wvalid     push request         o_wready   push accept
//   i_wdata      push data
//   o_rvalid     pop data valid       i_rready   pop accept
//   o_rdata      pop data (output queue head)
//   o_count      entries held (RF + read in flight + output queue)
//   o_rf_write   RF write strobe      o_rf_waddr / o_rf_wdata
//   o_rf_read    RF read strobe       o_rf_raddr / i_rf_rdata (next cycle)
module rf_fifo_ctrl #(
    parameter int wordWd = 12,
    parameter int DWd    = 32,
    parameter int AWd    = $clog2(wordWd)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_flush,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    input  logic [DWd-1:0]              i_wdata,
    output logic                        o_rvalid,
    input  logic                        i_rready,
    output logic [DWd-1:0]              o_rdata,
    output logic [$clog2(wordWd+3)-1:0] o_count,
    output logic                        o_rf_read,
    output logic                        o_rf_write,
    output logic [AWd-1:0]              o_rf_raddr,
    output logic [AWd-1:0]              o_rf_waddr,
    output logic [DWd-1:0]              o_rf_wdata,
    input  logic [DWd-1:0]              i_rf_rdata
);

    localparam int CntW = $clog2(wordWd + 3);
    localparam logic [AWd-1:0] LastAddr = AWd'(wordWd - 1);
    localparam logic [CntW-1:0] Depth = CntW'(wordWd);

    // RF bookkeeping
    logic [AWd-1:0]  wptr;
    logic [AWd-1:0]  rptr;
    logic [CntW-1:0] rf_cnt;
    logic            inflight;

    // output queue: head is what o_rdata shows, tail is the second slot
    logic [1:0]      oq_cnt;
    logic [DWd-1:0]  oq_head;
    logic [DWd-1:0]  oq_tail;

    logic            active;
    logic            push;
    logic            pop;
    logic            issue;
    logic            capture;
    logic [2:0]      oq_claim;
    logic [1:0]      oq_slot;

    function automatic logic [AWd-1:0] next_ptr(input logic [AWd-1:0] p);
        next_ptr = (p == LastAddr) ? '0 : p + AWd'(1);
    endfunction

    assign active   = !i_rst && !i_flush;

    // push side: only RF space counts, freed slots show up next cycle
    assign o_wready = (rf_cnt < Depth) && active;
    assign push     = i_wvalid && o_wready;

    // pop side
    assign o_rvalid = (oq_cnt != 2'd0) && !i_rst;
    assign pop      = o_rvalid && i_rready;

    // slots the queue will need once the in-flight read lands,
    // net of the pop happening this cycle
    assign oq_claim = 3'(oq_cnt) + 3'(inflight) - 3'(pop);

    // rf_cnt only counts entries written at an earlier edge, so a read
    // can never target the slot being written in the same cycle
    assign issue    = (rf_cnt != '0) && (oq_claim < 3'd2) && active;
    assign capture  = inflight;

    // where the returning word goes after this cycle's pop shifts the queue
    assign oq_slot  = oq_cnt - 2'(pop);

    assign o_rf_write = push;
    assign o_rf_waddr = wptr;
    assign o_rf_wdata = i_wdata;
    assign o_rf_read  = issue;
    assign o_rf_raddr = rptr;

    assign o_rdata  = oq_head;
    assign o_count  = rf_cnt + CntW'(inflight) + CntW'(oq_cnt);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wptr     <= '0;
            rptr     <= '0;
            rf_cnt   <= '0;
            inflight <= 1'b0;
        end else begin
            if (push) begin
                wptr <= next_ptr(wptr);
            end
            if (issue) begin
                rptr <= next_ptr(rptr);
            end
            rf_cnt   <= rf_cnt + CntW'(push) - CntW'(issue);
            inflight <= issue;
        end
    end

    // a flush or reset drops whatever read data is returning this cycle
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            oq_cnt  <= 2'd0;
            oq_head <= '0;
            oq_tail <= '0;
        end else begin
            oq_cnt <= oq_cnt + 2'(capture) - 2'(pop);
            if (pop) begin
                oq_head <= oq_tail;
            end
            if (capture && (oq_slot == 2'd0)) begin
                oq_head <= i_rf_rdata;
            end
            if (capture && (oq_slot == 2'd1)) begin
                oq_tail <= i_rf_rdata;
            end
        end
    end

endmodule
